// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide unit.
// Op encodings, FSM states and datapath widths.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int DLEN = 64;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } state_e;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                            input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath: one quotient bit per step strobe.
// Operates on unsigned magnitudes; sign fix-up is done by the caller.
module muldiv_div_core
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quo,
    output logic [XLEN-1:0] o_rem
);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_sub;
    logic            w_ge;

    // Shift next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        w_trial = {r_rem, r_quo[XLEN-1]};
        w_ge    = (w_trial >= {1'b0, r_div});
        w_sub   = w_trial[XLEN-1:0] - r_div;
    end

    // Load operands, then restore-or-keep one bit per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_rem <= w_ge ? w_sub : w_trial[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
        end
    end

    assign o_quo = r_quo;
    assign o_rem = r_rem;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences MULT/MULTU/DIV/DIVU, arbitrates MTHI/MTLO
// writes against pending results, and stalls dependent EX instructions.
module hilo_muldiv_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic            mthi_we,
    input  logic            mtlo_we,
    input  logic [XLEN-1:0] mt_data,
    input  logic            mf_req,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            div_by_zero
);

    localparam int CW = 8;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_opa;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic            r_mhi;
    logic            r_mlo;
    logic            r_done;
    logic            r_dbz;

    logic            w_busy;
    logic            w_load;
    logic            w_sdiv_in;
    logic [XLEN-1:0] w_dvd;
    logic [XLEN-1:0] w_dvs;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic [DLEN-1:0] w_xa;
    logic [DLEN-1:0] w_xb;
    logic [DLEN-1:0] w_prod;
    logic [XLEN-1:0] w_qfix;
    logic [XLEN-1:0] w_rfix;
    logic            w_wr_hi;
    logic            w_wr_lo;

    // Issue decode, magnitudes for the divider, product and sign fix-up.
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_sdiv_in = (op == OP_DIV);
        w_load    = (r_state == S_IDLE) && start_in
                    && op[1] && (opb != '0);
        w_dvd     = mag(opa, w_sdiv_in);
        w_dvs     = mag(opb, w_sdiv_in);
        w_xa      = {{XLEN{(r_op == OP_MULT) & r_opa[XLEN-1]}}, r_opa};
        w_xb      = {{XLEN{(r_op == OP_MULT) & r_opb[XLEN-1]}}, r_opb};
        w_prod    = w_xa * w_xb;
        w_qfix    = ((r_op == OP_DIV) && (r_opa[XLEN-1] ^ r_opb[XLEN-1]))
                    ? -w_quo : w_quo;
        w_rfix    = ((r_op == OP_DIV) && r_opa[XLEN-1]) ? -w_rem : w_rem;
        w_wr_hi   = !r_mhi && !mthi_we;
        w_wr_lo   = !r_mlo && !mtlo_we;
    end

    muldiv_div_core u_div (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_step     (r_state == S_DIV),
        .i_dividend (w_dvd),
        .i_divisor  (w_dvs),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

    // Sequencer FSM with HI/LO ownership and MT write masking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mhi   <= 1'b0;
            r_mlo   <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            if (mthi_we) r_hi <= mt_data;
            if (mtlo_we) r_lo <= mt_data;
            if (w_busy && mthi_we) r_mhi <= 1'b1;
            if (w_busy && mtlo_we) r_mlo <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_op  <= op;
                        r_opa <= opa;
                        r_opb <= opb;
                        r_mhi <= 1'b0;
                        r_mlo <= 1'b0;
                        if (!op[1]) begin
                            r_state <= S_MUL;
                            r_cnt   <= CW'(MUL_CYCLES - 1);
                        end else if (opb != '0) begin
                            r_state <= S_DIV;
                            r_cnt   <= CW'(DIV_CYCLES - 1);
                        end else begin
                            if (!mthi_we) r_hi <= opa;
                            if (!mtlo_we) r_lo <= '1;
                            r_done <= 1'b1;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        if (w_wr_hi) r_hi <= w_prod[DLEN-1:XLEN];
                        if (w_wr_lo) r_lo <= w_prod[XLEN-1:0];
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    if (r_cnt == '0) r_state <= S_FIX;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    if (w_wr_hi) r_hi <= w_rfix;
                    if (w_wr_lo) r_lo <= w_qfix;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = w_busy;
    assign stall       = w_busy && (mf_req || start_in);
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: vector table plus
// hand sequences for stall, MT arbitration and mid-op reset.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic        mf_req = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_by_zero;

    int n_chk = 0;
    int n_err = 0;

    hilo_muldiv_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_in    (start_in),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .mthi_we     (mthi_we),
        .mtlo_we     (mtlo_we),
        .mt_data     (mt_data),
        .mf_req      (mf_req),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          lat;
        logic        dbz;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        start_in = 1'b1;
        op       = o;
        opa      = a;
        opb      = b;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        int pulses;

        vt[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 4, 1'b0};
        vt[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4, 1'b0};
        vt[2]  = '{2'b00, 32'h7FFFFFFF, 32'd2, 32'h0, 32'hFFFFFFFE, 4, 1'b0};
        vt[3]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 4, 1'b0};
        vt[4]  = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
        vt[5]  = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0};
        vt[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 1'b0};
        vt[7]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 1'b0};
        vt[8]  = '{2'b11, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 33, 1'b0};
        vt[9]  = '{2'b11, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 0, 1'b1};
        vt[10] = '{2'b10, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b);
            chk($sformatf("v%0d_busy", i), busy, vt[i].lat != 0);
            wait_done(n);
            chk($sformatf("v%0d_lat", i), n, vt[i].lat);
            chk($sformatf("v%0d_hi", i), hi, vt[i].ehi);
            chk($sformatf("v%0d_lo", i), lo, vt[i].elo);
            chk($sformatf("v%0d_dbz", i), div_by_zero, vt[i].dbz);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_dbz_pulse", i), div_by_zero, 0);
            chk($sformatf("v%0d_idle", i), busy, 0);
        end

        // Stall on MF and on a second issue while a divide runs.
        issue(2'b11, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        mf_req   = 1'b1;
        start_in = 1'b1;
        op       = 2'b01;
        opa      = 32'd3;
        opb      = 32'd4;
        #1;
        bad = 0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (stall !== 1'b1) bad++;
            @(negedge clk);
            n++;
        end
        chk("stall_held", bad, 0);
        chk("stall_len", n, 29);
        chk("stall_drop", stall, 0);
        chk("stall_div_hi", hi, 32'd2);
        chk("stall_div_lo", lo, 32'd14);
        mf_req = 1'b0;
        @(negedge clk);
        start_in = 1'b0;
        chk("reissue_busy", busy, 1);
        wait_done(n);
        chk("reissue_lat", n, 4);
        chk("reissue_hi", hi, 32'h0);
        chk("reissue_lo", lo, 32'd12);
        @(negedge clk);

        // MTHI during a divide masks the HI result.
        issue(2'b11, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        mthi_we = 1'b1;
        mt_data = 32'hCAFE0000;
        @(negedge clk);
        mthi_we = 1'b0;
        chk("mthi_now", hi, 32'hCAFE0000);
        wait_done(n);
        chk("mthi_lat", n, 23);
        chk("mthi_kept", hi, 32'hCAFE0000);
        chk("mthi_lo", lo, 32'd14);
        @(negedge clk);

        // MTLO on the same edge as the multiply result write.
        issue(2'b01, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        mtlo_we = 1'b1;
        mt_data = 32'h0000AAAA;
        @(negedge clk);
        mtlo_we = 1'b0;
        chk("mtlo_same_done", done, 1);
        chk("mtlo_same_lo", lo, 32'h0000AAAA);
        chk("mtlo_same_hi", hi, 32'h0);
        @(negedge clk);

        // MTHI in IDLE together with a start: result overwrites it later.
        mthi_we = 1'b1;
        mt_data = 32'h00005555;
        issue(2'b01, 32'd2, 32'd3);
        mthi_we = 1'b0;
        chk("mt_idle_hi", hi, 32'h00005555);
        wait_done(n);
        chk("mt_idle_lat", n, 4);
        chk("mt_idle_res_hi", hi, 32'h0);
        chk("mt_idle_res_lo", lo, 32'd6);
        @(negedge clk);

        // Asynchronous reset in the middle of a divide.
        issue(2'b10, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_hi", hi, 32'h0);
        chk("mid_rst_lo", lo, 32'h0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("mid_rst_no_done", pulses, 0);
        chk("mid_rst_lo_kept", lo, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
